barrett_reduce_62: RTL and testbench

Pipelined Barrett modular reduction stage that consumes the 124-bit product from `karatsuba_multiply_62` and returns that product modulo a 62-bit odd modulus q. It sits directly downstream of the multiplier. Together the two blocks form the fixed-latency 62-bit modular multiplier of the datapath. The stage accepts one product per cycle, carries its modulus and constant alongside the data, and never stalls.

---
 rtl/barrett_reduce_62.sv | 106 ++++++++++
 tb/tb_barrett_reduce_62.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/barrett_reduce_62.sv
// Purpose    : Barrett reduction of a 124-bit product modulo a 62-bit odd modulus q (2^61 <= q < 2^62).
// Latency    : 4 cycles, fully pipelined, 1 beat/cycle; out_valid is in_valid delayed by 4 cycles.
// Backpressure: none; the stage never stalls and the consumer must take every out_valid beat.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (release synchronous to clk)
//   in_valid  product/q/mu valid this cycle
//   product   124-bit value c to reduce
//   q         62-bit modulus, bit 61 set
//   mu        64-bit Barrett constant floor(2^124 / q)
//   out_valid result valid this cycle
//   result    c mod q, in [0, q-1]; holds its last value between valid beats
module barrett_reduce_62 #(
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [123:0] product,
  input  logic [61:0]  q,
  input  logic [63:0]  mu,
  output logic         out_valid,
  output logic [61:0]  result
);

  // Valid shift chain: bit 0 = S1, bit LATENCY-1 = S4 (out_valid).
  logic [LATENCY-1:0] vld_d, vld_q;

  // S1: low word of c, modulus, and the upper 64 bits of t1 = (c >> 61) * mu.
  // Only t1 >> 63 is ever consumed, so the low 63 bits of t1 are not stored.
  logic [63:0] c1_d, c1_q;
  logic [61:0] m1_d, m1_q;
  logic [63:0] t1hi_d, t1hi_q;

  // S2: low word of c, modulus, t2 = (q3 * q) mod 2^64.
  logic [63:0] c2_d, c2_q;
  logic [61:0] m2_d, m2_q;
  logic [63:0] t2_d, t2_q;

  // S3: r0 = (c - t2) mod 2^64, modulus.
  logic [63:0] r0_d, r0_q;
  logic [61:0] m3_d, m3_q;

  // S4: final residue.
  logic [61:0] res_d, res_q;

  // S4 combinational corrections.
  logic [63:0] mx;
  logic [63:0] r1;
  logic [61:0] r2;

  always_comb begin
    vld_d  = {vld_q[LATENCY-2:0], in_valid};

    // S1: 63 x 64 multiply; q3 is bits [126:63] of the 127-bit product.
    c1_d   = product[63:0];
    m1_d   = q;
    t1hi_d = 64'(({64'd0, product[123:61]} * {63'd0, mu}) >> 63);

    // S2: the 64-bit multiply wraps, which is exactly the mod 2^64 we need.
    c2_d   = c1_q;
    m2_d   = m1_q;
    t2_d   = t1hi_q * {2'b00, m1_q};

    // S3: r0 < 3q < 2^64, so the wrapped difference is the true difference.
    r0_d   = c2_q - t2_q;
    m3_d   = m2_q;

    // S4: two conditional subtractions bring r0 from [0, 3q) into [0, q).
    mx     = {2'b00, m3_q};
    r1     = (r0_q >= mx) ? (r0_q - mx) : r0_q;
    r2     = (r1 >= mx) ? 62'(r1 - mx) : r1[61:0];
    res_d  = vld_q[LATENCY-2] ? r2 : res_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      c1_q   <= '0;
      m1_q   <= '0;
      t1hi_q <= '0;
      c2_q   <= '0;
      m2_q   <= '0;
      t2_q   <= '0;
      r0_q   <= '0;
      m3_q   <= '0;
      res_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      c1_q   <= c1_d;
      m1_q   <= m1_d;
      t1hi_q <= t1hi_d;
      c2_q   <= c2_d;
      m2_q   <= m2_d;
      t2_q   <= t2_d;
      r0_q   <= r0_d;
      m3_q   <= m3_d;
      res_q  <= res_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign result    = res_q;

endmodule

// File: tb/tb_barrett_reduce_62.sv
// Purpose    : Self-checking bench for barrett_reduce_62 (directed table, streaming, per-beat modulus, reset).
// Latency    : expects out_valid/result exactly 4 cycles after each driven in_valid.
// Backpressure: none; every cycle's out_valid and result are compared against a delay-line model.
module tb_barrett_reduce_62;

  localparam logic [61:0] QA = 62'h3FFF_FFFF_FFFF_FFC7; // 2^62 - 57
  localparam logic [61:0] QB = 62'h2000_0000_0000_000F; // 2^61 + 15
  localparam logic [61:0] QC = 62'h2000_0000_0000_0001; // 2^61 + 1

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [123:0] product;
  logic [61:0]  q;
  logic [63:0]  mu;
  logic         out_valid;
  logic [61:0]  result;

  int checks = 0;
  int errors = 0;

  // Delay-line model: index 0 = beat driven at the previous negedge.
  logic        hv[4];
  logic [61:0] hr[4];
  logic [61:0] exp_res;

  typedef struct {
    logic [123:0] p;
    logic [61:0]  qq;
    logic [63:0]  mu;
    logic [61:0]  e;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  barrett_reduce_62 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .product   (product),
    .q         (q),
    .mu        (mu),
    .out_valid (out_valid),
    .result    (result)
  );

  function automatic logic [63:0] calc_mu(input logic [61:0] m);
    logic [127:0] num;
    num = 128'd1 << 124;
    return 64'(num / {66'd0, m});
  endfunction

  function automatic logic [61:0] gold(input logic [123:0] c, input logic [61:0] m);
    return 62'({4'd0, c} % {66'd0, m});
  endfunction

  function automatic logic [123:0] rnd124();
    return 124'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      hv[i] = 1'b0;
      hr[i] = '0;
    end
    exp_res = '0;
  endtask

  // One cycle: at the negedge compare outputs against the model, then drive the next beat.
  task automatic cyc(input logic v, input logic [123:0] p, input logic [61:0] qq,
                     input logic [63:0] m, input logic [61:0] e);
    @(negedge clk);
    check("out_valid", {63'd0, out_valid}, {63'd0, hv[3]});
    if (hv[3]) exp_res = hr[3];
    check("result", {2'd0, result}, {2'd0, exp_res});
    for (int i = 3; i > 0; i--) begin
      hv[i] = hv[i-1];
      hr[i] = hr[i-1];
    end
    hv[0]    = v;
    hr[0]    = e;
    in_valid = v;
    product  = p;
    q        = qq;
    mu       = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, QA, '0, '0);
  endtask

  initial begin
    logic [63:0]  mu_a, mu_b, mu_c;
    logic [123:0] p, qa_w, qam1;
    int           lat, sent, seen;

    rst      = 1'b0;
    in_valid = 1'b0;
    product  = '0;
    q        = QA;
    mu       = '0;
    model_clear();

    mu_a = calc_mu(QA);
    mu_b = calc_mu(QB);
    mu_c = calc_mu(QC);
    qa_w = {62'd0, QA};
    qam1 = {62'd0, QA - 62'd1};

    vecs[0]  = '{124'd0,                  QA, mu_a, 62'd0};
    vecs[1]  = '{124'd5,                  QA, mu_a, 62'd5};
    vecs[2]  = '{qam1,                    QA, mu_a, QA - 62'd1};
    vecs[3]  = '{qa_w,                    QA, mu_a, 62'd0};
    vecs[4]  = '{qa_w * 124'd2,           QA, mu_a, 62'd0};
    vecs[5]  = '{qa_w * 124'd3 - 124'd1,  QA, mu_a, QA - 62'd1};
    vecs[6]  = '{qa_w * 124'd3 - 124'd2,  QA, mu_a, QA - 62'd2};
    vecs[7]  = '{qa_w << 62,              QA, mu_a, 62'd0};
    vecs[8]  = '{124'd1 << 62,            QA, mu_a, 62'd57};
    vecs[9]  = '{qam1 * qam1,             QA, mu_a, 62'd1};
    vecs[10] = '{{124{1'b1}},             QA, mu_a, 62'd3248};  // 2^124 = 57^2 mod q
    vecs[11] = '{{124{1'b1}},             QC, mu_c, 62'd3};     // 2^124 = 4 mod (2^61+1)
    vecs[12] = '{124'd1 << 122,           QC, mu_c, 62'd1};     // (2^61)^2 = 1 mod (2^61+1)

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", {2'd0, result}, 64'd0);
    rst = 1'b1;

    // Single-beat latency, bounded count.
    cyc(1'b1, 124'd5, QA, mu_a, 62'd5);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, '0, QA, '0, '0);
      if (out_valid && lat < 0) lat = i;
    end
    check("latency", 64'(lat), 64'd4);

    // Directed table with a gap after each beat, then back-to-back.
    foreach (vecs[i]) begin
      cyc(1'b1, vecs[i].p, vecs[i].qq, vecs[i].mu, vecs[i].e);
      cyc(1'b0, '0, QA, '0, '0);
    end
    idle(5);
    foreach (vecs[i]) cyc(1'b1, vecs[i].p, vecs[i].qq, vecs[i].mu, vecs[i].e);
    idle(5);

    // Per-beat modulus: alternate QA / QB every cycle.
    for (int i = 0; i < 40; i++) begin
      p = rnd124();
      if (i % 2 == 0) cyc(1'b1, p, QA, mu_a, gold(p, QA));
      else            cyc(1'b1, p, QB, mu_b, gold(p, QB));
    end
    idle(5);

    // Streaming: 10,000 random beats at ~70% duty.
    sent = 0;
    while (sent < 10000) begin
      p = rnd124();
      if ($urandom_range(0, 99) < 70) begin
        cyc(1'b1, p, QA, mu_a, gold(p, QA));
        sent++;
      end else begin
        cyc(1'b0, p, QA, mu_a, '0);
      end
    end
    idle(5);

    // Reset mid-stream: after 6 back-to-back beats, 3 are in flight and out_valid is high.
    for (int i = 0; i < 6; i++) begin
      p = rnd124();
      cyc(1'b1, p, QA, mu_a, gold(p, QA));
    end
    #1;
    rst = 1'b0;
    #1;
    check("rst_async_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_async_result", {2'd0, result}, 64'd0);
    model_clear();
    idle(2);
    // Release at this negedge and present a beat on the very first edge after release.
    p        = 124'd1 << 62;
    rst      = 1'b1;
    in_valid = 1'b1;
    product  = p;
    q        = QA;
    mu       = mu_a;
    hv[0]    = 1'b1;
    hr[0]    = 62'd57;
    seen     = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, QA, '0, '0);
      if (out_valid) seen++;
    end
    check("post_reset_beats", 64'(seen), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
